// File: rtl/read_miss_issuer_pkg.sv
// Shared definitions for the read-miss path (issuer and miss handler).
//   - default AXI address / ID widths and ROB tag width
//   - miss FIFO entry layout {tid, addr}, tid in the MSBs
//   - default bound on in-flight misses
package read_miss_issuer_pkg;

  localparam int unsigned AXI_ADDR_WIDTH      = 32;
  localparam int unsigned AXI_ID_WIDTH        = 4;
  localparam int unsigned TID_WIDTH           = 6;
  localparam int unsigned DEF_MAX_OUTSTANDING = 16;

  // Entry format at default widths; the miss handler unpacks pops with this.
  typedef struct packed {
    logic [TID_WIDTH-1:0]      tid;
    logic [AXI_ADDR_WIDTH-1:0] addr;
  } miss_entry_t;

endpackage

// File: rtl/read_miss_issuer_outstanding_counter.sv
// Up/down counter of misses issued on AR and not yet popped by the handler.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   i_inc        AR handshake this cycle
//   i_dec        miss handler popped the miss FIFO this cycle
//   o_cnt        current count
//   o_at_max     count has reached MAX_OUTSTANDING (new misses must stall)
module read_miss_issuer_outstanding_counter #(
  parameter int unsigned MAX_OUTSTANDING = 16,
  parameter int unsigned CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_inc,
  input  logic                 i_dec,
  output logic [CNT_WIDTH-1:0] o_cnt,
  output logic                 o_at_max
);

  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 w_at_max;
  logic                 w_at_zero;

  assign w_at_max  = (r_cnt >= CNT_WIDTH'(MAX_OUTSTANDING));
  assign w_at_zero = (r_cnt == '0);

  // inc and dec together cancel; each direction is guarded so the count
  // can neither wrap past MAX nor underflow below zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      case ({i_inc, i_dec})
        2'b10:   if (!w_at_max)  r_cnt <= r_cnt + CNT_WIDTH'(1);
        2'b01:   if (!w_at_zero) r_cnt <= r_cnt - CNT_WIDTH'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

`ifndef SYNTHESIS
  // A pop with nothing outstanding means the handler and issuer disagree.
  always_ff @(posedge clk) begin
    if (rst_n) assert (!(i_dec && !i_inc && w_at_zero));
  end
`endif

  assign o_cnt    = r_cnt;
  assign o_at_max = w_at_max;

endmodule

// File: rtl/read_miss_issuer.sv
// Read-miss issuer: accepts misses from tag check, pushes {tid, addr} into
// the miss FIFO, then issues the matching AR to the CXL controller. The push
// always happens one cycle before the AR, so FIFO order equals AR order.
// In-flight misses are bounded by an outstanding counter released by the
// handler's FIFO pop (resp_done_i).
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   miss_valid_i/miss_ready_o        miss handshake; miss_addr_i, miss_tid_i
//   write_en_o, full_i, wdata_fifo_o miss FIFO push side ({tid, addr})
//   arvalid_o/arready_i, araddr_o, arid_o   AR channel
//   resp_done_i                      one-cycle pulse on handler FIFO pop
//   outstanding_o                    current in-flight count
// Optional: define READ_MISS_ISSUER_PERF_EN to add miss_cnt_o / stall_cnt_o
// (32-bit saturating accepted-miss and stalled-cycle counters).
module read_miss_issuer
  import read_miss_issuer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = AXI_ADDR_WIDTH,
  parameter int unsigned TID_W           = TID_WIDTH,
  parameter int unsigned ID_WIDTH        = AXI_ID_WIDTH,
  parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int unsigned CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        miss_valid_i,
  output logic                        miss_ready_o,
  input  logic [ADDR_WIDTH-1:0]       miss_addr_i,
  input  logic [TID_W-1:0]            miss_tid_i,
  output logic                        write_en_o,
  input  logic                        full_i,
  output logic [ADDR_WIDTH+TID_W-1:0] wdata_fifo_o,
  output logic                        arvalid_o,
  input  logic                        arready_i,
  output logic [ADDR_WIDTH-1:0]       araddr_o,
  output logic [ID_WIDTH-1:0]         arid_o,
  input  logic                        resp_done_i,
  output logic [CNT_WIDTH-1:0]        outstanding_o
`ifdef READ_MISS_ISSUER_PERF_EN
  ,
  output logic [31:0]                 miss_cnt_o,
  output logic [31:0]                 stall_cnt_o
`endif
);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_REQ  = 1'b1;

  logic                  r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ID_WIDTH-1:0]   r_id;

  logic w_idle;
  logic w_ready;
  logic w_accept;
  logic w_ar_hs;
  logic w_at_max;

  assign w_idle = (r_state == S_IDLE);

  // rst_n is folded in so ready and push stay low for the whole reset, not
  // just after the first edge.
  assign w_ready  = rst_n && w_idle && !full_i && !w_at_max;
  assign w_accept = miss_valid_i && w_ready;
  assign w_ar_hs  = (r_state == S_REQ) && arready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_id    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_addr  <= miss_addr_i;
          r_state <= S_REQ;
        end
        S_REQ: if (arready_i) begin
          r_id    <= r_id + ID_WIDTH'(1);
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  read_miss_issuer_outstanding_counter #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CNT_WIDTH       (CNT_WIDTH)
  ) u_outstanding (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_inc    (w_ar_hs),
    .i_dec    (resp_done_i),
    .o_cnt    (outstanding_o),
    .o_at_max (w_at_max)
  );

  // The tid goes straight to the FIFO; only the address is needed again for AR.
  assign miss_ready_o = w_ready;
  assign write_en_o   = w_accept;
  assign wdata_fifo_o = {miss_tid_i, miss_addr_i};
  // State resets asynchronously, so AR valid drops as soon as rst_n falls.
  assign arvalid_o    = rst_n && (r_state == S_REQ);
  assign araddr_o     = r_addr;
  assign arid_o       = r_id;

`ifdef READ_MISS_ISSUER_PERF_EN
  logic [31:0] r_miss_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_miss_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_accept && !(&r_miss_cnt))
        r_miss_cnt <= r_miss_cnt + 32'd1;
      if (w_idle && miss_valid_i && !w_ready && !(&r_stall_cnt))
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign miss_cnt_o  = r_miss_cnt;
  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_read_miss_issuer.sv
module tb_read_miss_issuer;

  localparam int AW   = 32;
  localparam int TW   = 4;
  localparam int IW   = 2;
  localparam int MAXO = 2;
  localparam int CW   = $clog2(MAXO + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          miss_valid_i = 1'b0;
  logic          miss_ready_o;
  logic [AW-1:0] miss_addr_i = '0;
  logic [TW-1:0] miss_tid_i = '0;
  logic          write_en_o;
  logic          full_i = 1'b0;
  logic [AW+TW-1:0] wdata_fifo_o;
  logic          arvalid_o;
  logic          arready_i = 1'b1;
  logic [AW-1:0] araddr_o;
  logic [IW-1:0] arid_o;
  logic          resp_done_i = 1'b0;
  logic [CW-1:0] outstanding_o;
`ifdef READ_MISS_ISSUER_PERF_EN
  logic [31:0]   miss_cnt_o;
  logic [31:0]   stall_cnt_o;
`endif

  read_miss_issuer #(
    .ADDR_WIDTH(AW), .TID_W(TW), .ID_WIDTH(IW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .miss_valid_i(miss_valid_i), .miss_ready_o(miss_ready_o),
    .miss_addr_i(miss_addr_i), .miss_tid_i(miss_tid_i),
    .write_en_o(write_en_o), .full_i(full_i), .wdata_fifo_o(wdata_fifo_o),
    .arvalid_o(arvalid_o), .arready_i(arready_i),
    .araddr_o(araddr_o), .arid_o(arid_o),
    .resp_done_i(resp_done_i), .outstanding_o(outstanding_o)
`ifdef READ_MISS_ISSUER_PERF_EN
    , .miss_cnt_o(miss_cnt_o), .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_push = 0;
  logic [AW+TW-1:0] last_wdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a miss is "pending" from acceptance until its AR
  // handshake; accepted addresses queue up in FIFO order and must appear on
  // AR in the same order; in-flight count = ARs issued - pops, floored at 0.
  bit             m_pend;
  int             m_id;
  int             m_outs;
  logic [AW-1:0]  q_addr[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend = 0; m_id = 0; m_outs = 0; q_addr.delete();
    end else begin
      bit issued, accepted;
      issued   = m_pend && arready_i;
      accepted = !m_pend && !full_i && (m_outs < MAXO) && miss_valid_i;
      if (issued) begin
        void'(q_addr.pop_front());
        m_pend = 0;
        m_id   = (m_id + 1) % (1 << IW);
      end else if (accepted) begin
        q_addr.push_back(miss_addr_i);
        m_pend = 1;
      end
      m_outs = m_outs + int'(issued) - int'(resp_done_i);
      if (m_outs < 0) m_outs = 0;
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (write_en_o) n_push++;
    if (!rst_n) begin
      chk("rst_ready", miss_ready_o, 0);
      chk("rst_wen", write_en_o, 0);
      chk("rst_arvalid", arvalid_o, 0);
      chk("rst_outs", outstanding_o, 0);
    end else begin
      bit er;
      er = !m_pend && !full_i && (m_outs < MAXO);
      chk("ready", miss_ready_o, er);
      chk("wen", write_en_o, er && miss_valid_i);
      if (er && miss_valid_i) chk("wdata", wdata_fifo_o, {miss_tid_i, miss_addr_i});
      chk("arvalid", arvalid_o, m_pend);
      if (m_pend && q_addr.size() > 0) begin
        chk("araddr", araddr_o, q_addr[0]);
        chk("arid", arid_o, m_id);
      end
      chk("outs", outstanding_o, m_outs);
    end
  end

  // Present a miss and hold it until accepted (bounded). Returns #1 after the
  // edge that starts the AR cycle. rd=1 pulses resp_done_i in that AR cycle.
  task automatic do_miss(input logic [AW-1:0] a, input logic [TW-1:0] t, input bit rd);
    int n = 0;
    bit acc = 0;
    @(posedge clk); #1;
    miss_valid_i = 1; miss_addr_i = a; miss_tid_i = t;
    while (!acc && n < 50) begin
      @(negedge clk);
      if (miss_ready_o) begin acc = 1; last_wdata = wdata_fifo_o; end
      @(posedge clk); #1;
      n++;
    end
    miss_valid_i = 0;
    chk("accept_timeout", acc, 1);
    if (rd) begin
      resp_done_i = 1;
      @(posedge clk); #1;
      resp_done_i = 0;
    end
  endtask

  task automatic pulse_done();
    @(posedge clk); #1 resp_done_i = 1;
    @(posedge clk); #1 resp_done_i = 0;
  endtask

  initial begin
    int p0;
    #12;
    chk("reset_outs_lit", outstanding_o, 0);
    chk("reset_arvalid_lit", arvalid_o, 0);
    #10 rst_n = 1;

    // Single miss, AR ready high.
    do_miss(32'h1000, 4'd3, 0);
    chk("t1_wdata_lit", last_wdata, 36'h3_0000_1000);
    @(negedge clk);
    chk("t1_arvalid_lit", arvalid_o, 1);
    chk("t1_araddr_lit", araddr_o, 32'h1000);
    chk("t1_arid_lit", arid_o, 0);
    @(negedge clk);
    chk("t1_outs_lit", outstanding_o, 1);

    // AR held off for 5 cycles.
    arready_i = 0;
    p0 = n_push;
    do_miss(32'h2000, 4'd5, 0);
    repeat (5) begin
      @(negedge clk);
      chk("t2_arvalid_lit", arvalid_o, 1);
      chk("t2_araddr_lit", araddr_o, 32'h2000);
      chk("t2_arid_lit", arid_o, 1);
      chk("t2_ready_lit", miss_ready_o, 0);
    end
    chk("t2_one_push", n_push - p0, 1);
    @(posedge clk); #1 arready_i = 1;
    @(posedge clk); @(negedge clk);
    chk("t2_outs_lit", outstanding_o, 2);

    // FIFO full blocks acceptance.
    pulse_done(); pulse_done();
    @(posedge clk); #1;
    full_i = 1; miss_valid_i = 1; miss_addr_i = 32'h3000; miss_tid_i = 4'd7;
    repeat (3) begin
      @(negedge clk);
      chk("t3_full_ready_lit", miss_ready_o, 0);
      chk("t3_full_wen_lit", write_en_o, 0);
    end
    @(posedge clk); #1 full_i = 0;
    @(negedge clk);
    chk("t3_accept_lit", write_en_o, 1);
    @(posedge clk); #1 miss_valid_i = 0;

    // Outstanding limit of 2: third miss stalls until a pop.
    pulse_done();
    do_miss(32'h4000, 4'd1, 0);
    @(posedge clk); @(negedge clk);
    chk("t4_outs1_lit", outstanding_o, 1);
    do_miss(32'h4100, 4'd2, 0);
    @(negedge clk);
    chk("t4_arid_wrap_lit", arid_o, 0);
    @(posedge clk); @(negedge clk);
    chk("t4_outs2_lit", outstanding_o, 2);
    fork
      do_miss(32'h4200, 4'd4, 0);
      begin
        repeat (4) begin
          @(negedge clk);
          chk("t4_stall_lit", miss_ready_o, 0);
        end
        @(posedge clk); #1 resp_done_i = 1;
        @(posedge clk); #1 resp_done_i = 0;
      end
    join
    @(posedge clk); @(negedge clk);
    chk("t4_outs_after_lit", outstanding_o, 2);

    // Back-to-back with pop coinciding with each AR handshake.
    pulse_done();
    for (int i = 0; i < 5; i++) begin
      do_miss(32'h5000 + 32'(i * 64), TW'(i), 1);
      @(negedge clk);
      chk("t5_outs_lit", outstanding_o, 1);
    end

    // Reset while an AR is pending.
    arready_i = 0;
    do_miss(32'h6000, 4'd2, 0);
    @(negedge clk);
    chk("t6_pre_arvalid_lit", arvalid_o, 1);
    #2 rst_n = 0;
    #1;
    chk("t6_async_arvalid_lit", arvalid_o, 0);
    chk("t6_async_ready_lit", miss_ready_o, 0);
    chk("t6_async_outs_lit", outstanding_o, 0);
    @(negedge clk);
    #2 rst_n = 1;
    arready_i = 1;
    @(negedge clk);
    chk("t6_ready_lit", miss_ready_o, 1);
    chk("t6_arid_lit", arid_o, 0);
    do_miss(32'h7000, 4'd9, 0);
    @(negedge clk);
    chk("t6_post_arid_lit", arid_o, 0);
    chk("t6_post_araddr_lit", araddr_o, 32'h7000);
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/read_miss_issuer.md
Name: read_miss_issuer

Overview:
- Initiator side of the read-miss path toward the CXL controller.
- Accepts read misses from the tag-check stage and records {tid, addr} in R_MISS_FIFO, so the miss handler can pair returning data in order.
- Issues the matching AR request (address + ID) to the CXL controller.
- Bounds in-flight misses with an outstanding counter; the counter is released by the miss handler's FIFO pop.

Parameters:
- ADDR_WIDTH, `AXI_ADDR_WIDTH, request address width
- TID_WIDTH, `TID_WIDTH, ROB transaction tag width
- ID_WIDTH, `AXI_ID_WIDTH, AR ID width toward CXL controller
- MAX_OUTSTANDING, 16, maximum misses issued and not yet returned (1..2^16)
- CNT_WIDTH, $clog2(MAX_OUTSTANDING+1), outstanding counter width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- miss_valid_i  in  1  miss request valid (tag-check stage)
- miss_ready_o  out  1  miss accepted when high with valid
- miss_addr_i  in  ADDR_WIDTH  miss line address
- miss_tid_i  in  TID_WIDTH  miss ROB tag
- write_en_o  out  1  R_MISS_FIFO push strobe
- full_i  in  1  R_MISS_FIFO full
- wdata_fifo_o  out  ADDR_WIDTH+TID_WIDTH  FIFO entry {tid, addr}, tid in MSBs
- arvalid_o  out  1  AR valid to CXL controller
- arready_i  in  1  AR ready from CXL controller
- araddr_o  out  ADDR_WIDTH  AR address
- arid_o  out  ID_WIDTH  AR ID
- resp_done_i  in  1  one-cycle pulse; miss handler popped R_MISS_FIFO (read_en)
- outstanding_o  out  CNT_WIDTH  current in-flight count

Behaviour:
- Reset (async assert, sync release): state S_IDLE; outstanding, ID counter, and addr/tid registers all 0.
- While rst_n is low: miss_ready_o, write_en_o, and arvalid_o are all 0.
- S_IDLE:
  - miss_ready_o = !full_i && (outstanding < MAX_OUTSTANDING).
  - On miss_valid_i && miss_ready_o:
    - write_en_o = 1 in the same cycle, with wdata_fifo_o = {miss_tid_i, miss_addr_i} driven combinationally.
    - Addr is latched.
    - Next state is S_REQ.
  - No push occurs without acceptance.
- S_REQ:
  - miss_ready_o = 0.
  - arvalid_o = 1, with araddr_o and arid_o driven from registers and held stable until handshake.
  - On arready_i: outstanding increments, the ID counter increments (wraps mod 2^ID_WIDTH), and next state is S_IDLE.
  - arvalid_o is never withdrawn before handshake.
- Latency and throughput:
  - A miss accepted in cycle N raises arvalid_o in N+1.
  - Minimum spacing is 2 cycles per miss.
- Ordering: the FIFO push always precedes the AR issue, so FIFO order equals AR order. No response can precede its FIFO entry.
- Outstanding counter:
  - +1 on AR handshake; -1 on resp_done_i.
  - Both in the same cycle: unchanged.
  - resp_done_i at 0: counter stays 0; a simulation assertion fires.
  - A miss at counter == MAX_OUTSTANDING is stalled (ready 0) until resp_done_i.
- full_i rising while in S_REQ: no effect; the AR still completes.
- Reset mid-S_REQ: arvalid_o drops immediately and the counter clears. Upstream and the CXL controller are reset together.

Optional Feature:
- Macro: READ_MISS_ISSUER_PERF_EN.
- With the macro defined, two extra outputs are added:
  - miss_cnt_o [31:0]: counts accepted misses.
  - stall_cnt_o [31:0]: counts cycles with miss_valid_i && !miss_ready_o in S_IDLE.
  - Both reset to 0 and saturate at all-ones.
- Without the macro: these ports and their logic do not exist.

Decomposition:
- Shared package/TYPEDEF.svh holds:
  - AXI width macros;
  - the miss FIFO entry typedef {tid, addr} shared with the miss handler;
  - the default MAX_OUTSTANDING.
- One natural sub-module: outstanding_counter (up/down, saturation guard, simultaneous inc/dec).

Test Plan:
- Single miss, addr 0x1000, tid 3, arready_i high: write_en_o in cycle N with wdata = {3, 0x1000}; arvalid_o in N+1 with araddr 0x1000, arid 0; outstanding 1.
- arready_i held low 5 cycles: arvalid, araddr, and arid stay stable; miss_ready_o stays 0; one push only.
- full_i=1 with miss pending: miss_ready_o=0, no push; full_i drops: accepted next cycle.
- MAX_OUTSTANDING=2, three misses with no resp_done_i: third stalled; a resp_done_i pulse releases it; counter sequence 1,2,2(-1 +1).
- Back-to-back misses with resp_done_i on the same cycle as an AR handshake: counter unchanged; arid wraps from 2^ID_WIDTH-1 to 0.
- rst_n asserted during S_REQ: arvalid_o falls asynchronously; after release, state is IDLE, outstanding 0, arid 0.
